// File: rtl/powlib_ipmaxilite.sv
// powlib_ipmaxilite: PLB-to-AXI4-Lite master bridge, one single-beat transaction in flight.
// Define POWLIB_IPMAXI_ERRCNT_EN to build the saturating non-OKAY response counter on errcnt.
module powlib_ipmaxilite #(
   parameter int unsigned B_BPD = 4,
   parameter int unsigned B_AW = 32,
   parameter int unsigned B_OPW = 4,
   parameter logic [B_AW-1:0] B_BASE = '0,
   parameter logic [B_OPW-1:0] OP_WRITE = '0,
   parameter logic [B_OPW-1:0] OP_READ = B_OPW'(1),
   localparam int unsigned B_DW = 8*B_BPD,
   localparam int unsigned B_BEW = B_BPD,
   localparam int unsigned B_WW = B_DW+B_BEW+B_OPW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [B_AW-1:0]   wraddr,
   input  logic [B_WW-1:0]   wrdata,
   input  logic              wrvld,
   output logic              wrrdy,
   output logic [B_AW-1:0]   rdaddr,
   output logic [B_WW-1:0]   rddata,
   output logic              rdvld,
   input  logic              rdrdy,
   output logic [B_AW-1:0]   awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [B_DW-1:0]   wdata,
   output logic [B_BEW-1:0]  wstrb,
   output logic              wvalid,
   input  logic              wready,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   output logic [B_AW-1:0]   araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [B_DW-1:0]   rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [7:0]        errcnt
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RD_RET} state_t;

   state_t           state, state_nxt;
   logic [B_OPW-1:0] req_op;
   logic             wr_acc;

   assign req_op = wrdata[B_DW+B_BEW +: B_OPW];
   assign wr_acc = wrvld && wrrdy;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wr_acc) begin
               if (req_op == OP_WRITE)
                  state_nxt = WR_REQ;
               else if (req_op == OP_READ)
                  state_nxt = RD_REQ;
            end
         end
         // AW and W complete independently; leave once neither is still pending.
         WR_REQ:  if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = WR_RSP;
         WR_RSP:  if (bvalid) state_nxt = IDLE;
         RD_REQ:  if (arready) state_nxt = RD_RSP;
         RD_RSP:  if (rvalid) state_nxt = RD_RET;
         RD_RET:  if (rdrdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake flags are decoded from the next state so every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         wrrdy   <= 1'b0;
         bready  <= 1'b0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         rdvld   <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         awaddr  <= '0;
         araddr  <= '0;
         wdata   <= '0;
         wstrb   <= '0;
         rdaddr  <= '0;
         rddata  <= '0;
      end else begin
         state   <= state_nxt;
         wrrdy   <= (state_nxt == IDLE);
         bready  <= (state_nxt == WR_RSP);
         arvalid <= (state_nxt == RD_REQ);
         rready  <= (state_nxt == RD_RSP);
         rdvld   <= (state_nxt == RD_RET);
         if (state == IDLE && wr_acc) begin
            if (req_op == OP_WRITE) begin
               awaddr  <= wraddr - B_BASE;
               wdata   <= wrdata[0 +: B_DW];
               wstrb   <= wrdata[B_DW +: B_BEW];
               awvalid <= 1'b1;
               wvalid  <= 1'b1;
            end else if (req_op == OP_READ) begin
               araddr <= wraddr - B_BASE;
               rdaddr <= B_AW'(wrdata[0 +: B_DW]);
            end
         end
         if (state == WR_REQ) begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
         end
         if (state == RD_RSP && rvalid)
            rddata <= {OP_WRITE, {B_BEW{1'b1}}, rdata};
      end
   end

`ifdef POWLIB_IPMAXI_ERRCNT_EN
   logic err_hit;

   assign err_hit = (bvalid && bready && bresp != 2'b00) ||
                    (rvalid && rready && rresp != 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         errcnt <= '0;
      else if (err_hit && errcnt != 8'hFF)
         errcnt <= errcnt + 8'd1;
   end
`else
   logic unused_resp;

   assign unused_resp = ^{bresp, rresp};
   assign errcnt = 8'h00;
`endif

endmodule

// File: tb/tb_powlib_ipmaxilite.sv
// tb_powlib_ipmaxilite: directed self-checking bench for the PLB-to-AXI4-Lite master bridge.
// Expects errcnt=4 after the error sequence when POWLIB_IPMAXI_ERRCNT_EN is defined, else 0.
module tb_powlib_ipmaxilite;

   localparam logic [3:0] OP_W = 4'd0;
   localparam logic [3:0] OP_R = 4'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wraddr;
   logic [39:0] wrdata;
   logic        wrvld;
   logic        wrrdy;
   logic [31:0] rdaddr;
   logic [39:0] rddata;
   logic        rdvld;
   logic        rdrdy;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [7:0]  errcnt;

   int total = 0;
   int bad = 0;
   int lowcnt;

   always #5 clk = ~clk;

   powlib_ipmaxilite #(
      .B_BPD(4),
      .B_AW(32),
      .B_OPW(4),
      .B_BASE(32'h5000_0000),
      .OP_WRITE(4'd0),
      .OP_READ(4'd1)
   ) dut (
      .clk(clk), .rst(rst),
      .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
      .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .errcnt(errcnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Entered #1 after a rising edge; returns #1 after the edge that accepts the B.
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [1:0] resp, input int aw_wait, input int w_wait,
                           input logic [31:0] exp_aw, output int low);
      int n;
      bit aw_done, w_done;
      low = 0;
      wraddr = a; wrdata = {OP_W, be, d}; wrvld = 1'b1;
      chk("wr_accept_rdy", wrrdy, 1);
      @(posedge clk); #1;
      wrvld = 1'b0;
      n = 0; aw_done = 0; w_done = 0;
      while (!(aw_done && w_done) && n < 64) begin
         awready = (n >= aw_wait);
         wready  = (n >= w_wait);
         chk("wr_busy", wrrdy, 0);
         if (wrrdy == 1'b0) low++;
         chk("wr_bready_early", bready, 0);
         if (!aw_done) begin
            chk("awvalid_hold", awvalid, 1);
            chk("awaddr", awaddr, exp_aw);
         end else
            chk("awvalid_drop", awvalid, 0);
         if (!w_done) begin
            chk("wvalid_hold", wvalid, 1);
            chk("wdata", wdata, d);
            chk("wstrb", wstrb, be);
         end else
            chk("wvalid_drop", wvalid, 0);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready) w_done = 1;
         @(posedge clk); #1;
         n++;
      end
      awready = 1'b0; wready = 1'b0;
      chk("wr_hs_timeout", aw_done && w_done, 1);
      chk("wr_valids_low", {awvalid, wvalid}, 2'b00);
      bvalid = 1'b1; bresp = resp;
      chk("bready", bready, 1);
      chk("wr_busy_b", wrrdy, 0);
      if (wrrdy == 1'b0) low++;
      @(posedge clk); #1;
      bvalid = 1'b0; bresp = 2'b00;
      chk("wr_done_rdy", wrrdy, 1);
      chk("wr_done_bready", bready, 0);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] ret, input int rdelay,
                          input int rwait, input logic [31:0] v, input logic [1:0] resp,
                          input bit block);
      logic [63:0] exp_rd;
      exp_rd = {24'h0, OP_W, 4'hF, v};
      wraddr = a; wrdata = {OP_R, 4'h0, ret}; wrvld = 1'b1;
      chk("rd_accept_rdy", wrrdy, 1);
      @(posedge clk); #1;
      wrvld = 1'b0;
      arready = 1'b1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a - 32'h5000_0000);
      chk("rd_busy", wrrdy, 0);
      @(posedge clk); #1;
      arready = 1'b0;
      chk("arvalid_drop", arvalid, 0);
      for (int i = 0; i < rdelay; i++) begin
         chk("rready_wait", rready, 1);
         @(posedge clk); #1;
      end
      rvalid = 1'b1; rdata = v; rresp = resp;
      chk("rready", rready, 1);
      @(posedge clk); #1;
      rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      chk("rready_drop", rready, 0);
      if (block) begin
         wraddr = 32'h5000_0200; wrdata = {OP_W, 4'hF, 32'h0BAD_0BAD}; wrvld = 1'b1;
      end
      for (int i = 0; i < rwait; i++) begin
         chk("rdvld_hold", rdvld, 1);
         chk("rdaddr_hold", rdaddr, ret);
         chk("rddata_hold", rddata, exp_rd);
         chk("ret_no_accept", wrrdy, 0);
         chk("ret_no_aw", awvalid, 0);
         @(posedge clk); #1;
      end
      rdrdy = 1'b1; wrvld = 1'b0;
      chk("rdvld", rdvld, 1);
      chk("rdaddr", rdaddr, ret);
      chk("rddata", rddata, exp_rd);
      chk("rddata_field", rddata[31:0], v);
      chk("rddata_be", rddata[35:32], 4'hF);
      chk("rddata_op", rddata[39:36], OP_W);
      @(posedge clk); #1;
      rdrdy = 1'b0;
      chk("rd_done_rdvld", rdvld, 0);
      chk("rd_done_rdy", wrrdy, 1);
   endtask

   initial begin
      rst = 1'b1;
      wraddr = '0; wrdata = '0; wrvld = 1'b0; rdrdy = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
      arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;

      #2;
      chk("rst_valids", {wrrdy, rdvld, awvalid, wvalid, bready, arvalid, rready}, 7'b0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_rddata", rddata, 0);
      chk("rst_errcnt", errcnt, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rel_wrrdy_low", wrrdy, 0);
      @(posedge clk); #1;
      chk("rel_wrrdy_high", wrrdy, 1);

      do_write(32'h5000_0010, 32'hA5A5_1234, 4'b0011, 2'b00, 0, 0, 32'h0000_0010, lowcnt);
      chk("wr_low_cycles", lowcnt, 2);

      do_read(32'h5000_0020, 32'h5001_0040, 5, 0, 32'hDEAD_BEEF, 2'b00, 0);

      do_write(32'h5000_0100, 32'h1122_3344, 4'hF, 2'b00, 3, 0, 32'h0000_0100, lowcnt);
      chk("wr_skew_low_cycles", lowcnt, 5);

      do_read(32'h5000_0030, 32'h5002_0000, 0, 10, 32'h0123_4567, 2'b00, 1);

      // Unknown op is consumed and dropped.
      wraddr = 32'h5000_0040; wrdata = {4'd7, 4'hF, 32'hFFFF_FFFF}; wrvld = 1'b1;
      @(posedge clk); #1;
      wrvld = 1'b0;
      chk("drop_wrrdy", wrrdy, 1);
      chk("drop_valids", {awvalid, wvalid, arvalid}, 3'b000);
      chk("errcnt_clean", errcnt, 0);

      for (int i = 0; i < 3; i++)
         do_write(32'h5000_0050, 32'hCAFE_0000 + i, 4'hF, 2'b10, 0, 0, 32'h0000_0050, lowcnt);
      do_read(32'h5000_0060, 32'h5003_0000, 1, 0, 32'h7777_8888, 2'b11, 0);
`ifdef POWLIB_IPMAXI_ERRCNT_EN
      chk("errcnt", errcnt, 4);
`else
      chk("errcnt", errcnt, 0);
`endif

      // Reset while AW/W are pending.
      awready = 1'b0; wready = 1'b0;
      wraddr = 32'h5000_0070; wrdata = {OP_W, 4'hF, 32'h5555_AAAA}; wrvld = 1'b1;
      @(posedge clk); #1;
      wrvld = 1'b0;
      chk("pre_rst_awvalid", awvalid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valids", {wrrdy, awvalid, wvalid, bready}, 4'b0);
      chk("async_rst_awaddr", awaddr, 0);
      chk("async_rst_errcnt", errcnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst2_wrrdy_low", wrrdy, 0);
      @(posedge clk); #1;
      chk("rst2_wrrdy_high", wrrdy, 1);
      do_write(32'h5000_0080, 32'h8765_4321, 4'b1100, 2'b00, 0, 0, 32'h0000_0080, lowcnt);
      chk("post_rst_low_cycles", lowcnt, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/powlib_ipmaxilite.md
# powlib_ipmaxilite

AXI4-Lite master bridge that is the counterpart of the IP slave-AXI-to-PLB block. It accepts PLB write and read requests from one crossbar read port and issues them as single-beat AXI4-Lite transactions to an external slave (e.g. a Xilinx IP interconnect port). Read results go back onto the PLB as write packets to the requester's return address. One transaction is outstanding at a time.

## Interface
Parameters:
- B_BPD, 4, bytes per data word; B_DW = 8*B_BPD, B_BEW = B_BPD
- B_AW, 32, PLB and AXI address width
- B_OPW, 4, PLB op field width; B_WW = B_DW+B_BEW+B_OPW; packing: data [0+:B_DW], be [B_DW+:B_BEW], op [B_DW+B_BEW+:B_OPW]
- B_BASE, 32'h0, subtracted from the PLB address to form the AXI address (modulo 2^B_AW)
- OP_WRITE, 4'd0, PLB write op code
- OP_READ, 4'd1, PLB read op code; the data field carries the return address

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wraddr, wrdata, wrvld, wrrdy  in/in/in/out  B_AW/B_WW/1/1  PLB request input from the crossbar
- rdaddr, rddata, rdvld, rdrdy  out/out/out/in  B_AW/B_WW/1/1  PLB read-return output to the crossbar
- awaddr, awvalid, awready  out/out/in  B_AW/1/1
- wdata, wstrb, wvalid, wready  out/out/out/in  B_DW/B_BEW/1/1
- bresp, bvalid, bready  in/in/out  2/1/1
- araddr, arvalid, arready  out/out/in  B_AW/1/1
- rdata, rresp, rvalid, rready  in/in/in/out  B_DW/2/1/1
- errcnt  out  8  count of non-OKAY responses (see Configuration)

## Operation
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RD_RET.
- IDLE: wrrdy=1. On wrvld&wrrdy, register the address, data, be and op. OP_WRITE goes to WR_REQ. OP_READ goes to RD_REQ. Any other op is consumed and dropped, and the FSM stays in IDLE.
- WR_REQ: awvalid and wvalid assert together. awaddr=wraddr-B_BASE, wdata=data, wstrb=be. Each valid deasserts independently after its own handshake, in either order or the same cycle. When both are done, go to WR_RSP.
- WR_RSP: bready=1. On bvalid go to IDLE. bresp is checked only for errcnt.
- RD_REQ: arvalid=1 with araddr=wraddr-B_BASE. On arready go to RD_RSP.
- RD_RSP: rready=1. On rvalid, capture rdata and go to RD_RET.
- RD_RET: rdvld=1, rdaddr=captured return address, rddata={OP_WRITE, all-ones be, rdata}. Hold until rdrdy, then go to IDLE.
- Outputs are stable while their valid is high and not yet accepted.
- Reset: every state returns to IDLE immediately and all valid/ready outputs are 0. A partially issued AXI transaction is abandoned, so the AXI slave must share rst.

## Timing
- Reset values:
  - wrrdy=0, rdvld=0, awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0.
  - All address/data outputs are 0, errcnt=0.
  - wrrdy rises at the first clk edge after rst deasserts.
- All outputs are registered; there is no combinational path from input to output.
- Write, zero-wait slave: accept at edge 0; awvalid/wvalid high in cycle 1; handshake at edge 1; bready high in cycle 2; bvalid accepted at edge 2; wrrdy high again in cycle 3. That is 3 cycles per write.
- Read, zero-wait slave and crossbar: accept at edge 0; AR handshake at edge 1; R at edge 2; rdvld high in cycle 3; rdrdy at edge 3; wrrdy high again in cycle 4. That is 4 cycles per read.
- wrrdy is 0 in every state other than IDLE. No request is accepted while a response is pending.

## Configuration
- POWLIB_IPMAXI_ERRCNT_EN defined:
  - errcnt increments by 1 on each accepted B with bresp≠OKAY and each accepted R with rresp≠OKAY.
  - The count saturates at 8'hFF and is cleared only by rst.
  - Read data is returned unchanged regardless of rresp.
- Undefined: errcnt is tied to 8'h00 and no counter logic is built.

## Test plan
- Write 0x5000_0010, data 0xA5A5_1234, be 4'b0011, B_BASE=0x5000_0000, zero-wait slave -> awaddr=0x10, wdata=0xA5A5_1234, wstrb=4'b0011; wrrdy low for exactly 2 cycles.
- Read 0x5000_0020 with return address 0x5001_0040; slave returns 0xDEAD_BEEF after a 5-cycle rvalid delay -> rdaddr=0x5001_0040, rddata data field=0xDEAD_BEEF, be=4'hF, op=OP_WRITE.
- Slave asserts wready 3 cycles before awready -> wvalid drops after its handshake, awvalid is held, and exactly one B is awaited.
- rdrdy held low for 10 cycles during RD_RET -> rdvld and rddata stay stable; no new request is accepted while wrvld is high.
- With ERRCNT_EN, 3 writes with bresp=SLVERR and 1 read with rresp=DECERR -> errcnt=4. Without the macro, errcnt=0.
- rst asserted while in WR_REQ -> all valids drop asynchronously; wrrdy=1 one edge after release; the next write completes normally.
